// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO side signals of the FIFO write-port arbiter.
// slave: the arbiter. master: producers plus FIFO (or a bench standing in for them).
interface fifo_wr_arbiter_if #(
  parameter int unsigned K = 8,
  parameter int unsigned R = 2
);
  logic [R-1:0]   req;
  logic [R*K-1:0] din_bus;
  logic [R-1:0]   ack;
  logic [R-1:0]   grant;
  logic           fifo_full;
  logic           fifo_write;
  logic [K-1:0]   fifo_din;

  modport master (
    output req, din_bus, fifo_full,
    input  ack, grant, fifo_write, fifo_din
  );

  modport slave (
    input  req, din_bus, fifo_full,
    output ack, grant, fifo_write, fifo_din
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between R producers.
// A grant lasts for up to BURST words and is dropped early when the owner stops requesting.
// Writes are gated by fifo_full; a full FIFO stalls the owner without timeout.
// Optional feature: define ARB_STALL_CNT_EN to add a saturating 16-bit stall_cnt output
// counting cycles in which the owner requests but the FIFO is full.
module fifo_wr_arbiter #(
  parameter int unsigned K     = 8,
  parameter int unsigned R     = 2,
  parameter int unsigned BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  bus
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int unsigned IdxW = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned CntW = $clog2(BURST + 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [R-1:0]    grant_q, grant_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] scan_idx;
  logic            owner_req;
  logic [K-1:0]    owner_din;
  logic            write_en;

  // Round-robin pick: first requester starting at rr_ptr, wrapping modulo R.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < R; k++) begin
      scan_idx = IdxW'((32'(rr_ptr_q) + k) % R);
      if (!pick_valid && bus.req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Owner's request bit and data slice.
  always_comb begin
    owner_req = bus.req[owner_q];
    owner_din = '0;
    for (int unsigned i = 0; i < R; i++) begin
      if (owner_q == IdxW'(i)) begin
        owner_din = bus.din_bus[i*K +: K];
      end
    end
  end

  // Next-state logic and combinational write-port outputs.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    write_en       = 1'b0;
    bus.ack        = '0;
    bus.fifo_write = 1'b0;
    bus.fifo_din   = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StGrant;
          owner_d = pick_idx;
          grant_d = R'(1) << pick_idx;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        write_en       = owner_req & ~bus.fifo_full;
        bus.fifo_write = write_en;
        bus.fifo_din   = owner_din;
        if (write_en) begin
          bus.ack = R'(1) << owner_q;
          cnt_d   = cnt_q + CntW'(1);
        end
        // Full FIFO with a live request is a stall, not a release.
        if (!owner_req || (write_en && (cnt_d == CntW'(BURST)))) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = (owner_q == IdxW'(R - 1)) ? '0 : owner_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.grant = grant_q;

  // State registers, asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Count owner-stalled-by-full cycles, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StGrant) && owner_req && bus.fifo_full &&
                 (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
